// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle UI
// events (press, click, release, long-press, auto-repeat) plus a held level.
//
// Ports:
//   clock          system clock, sole clock domain
//   reset_n        asynchronous active-low reset
//   button_level   debounced level, synchronous to clock, 1 = pressed
//   long_periods   clocks from press_pulse to long_pulse (0 = long/repeat off)
//   repeat_delay   clocks from long_pulse to first repeat_pulse (0 = repeat off)
//   repeat_period  clocks between repeat_pulse ticks (0 = single repeat only)
//   press_pulse    1-cycle pulse, press accepted
//   click_pulse    1-cycle pulse, released before long_pulse
//   release_pulse  1-cycle pulse, any accepted press released
//   long_pulse     1-cycle pulse, hold reached long_periods
//   repeat_pulse   1-cycle pulse, auto-repeat tick
//   held           high while a press is active
module button_event_decoder #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             button_level,
    input  logic [CNT_W-1:0] long_periods,
    input  logic [CNT_W-1:0] repeat_delay,
    input  logic [CNT_W-1:0] repeat_period,
    output logic             press_pulse,
    output logic             click_pulse,
    output logic             release_pulse,
    output logic             long_pulse,
    output logic             repeat_pulse,
    output logic             held
);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_PRESSED,
        ST_LONG,
        ST_REPEAT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] count_inc_c;
    logic             long_hit_c;
    logic             delay_hit_c;
    logic             period_hit_c;

    // Saturating hold-time increment.
    assign count_inc_c  = (count == CNT_MAX) ? count : count + CNT_ONE;

    // Threshold checks; a zero threshold disables that stage. >= lets a
    // threshold lowered mid-hold fire on the next edge.
    assign long_hit_c   = (long_periods  != '0) && (count >= long_periods);
    assign delay_hit_c  = (repeat_delay  != '0) && (count >= repeat_delay);
    assign period_hit_c = (repeat_period != '0) && (count >= repeat_period);

    // Event FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_ARM;
            count         <= '0;
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            click_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            unique case (state)
                // A button held through reset must be seen released first.
                ST_ARM: begin
                    if (!button_level) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (button_level) begin
                        state       <= ST_PRESSED;
                        count       <= CNT_ONE;
                        press_pulse <= 1'b1;
                        held        <= 1'b1;
                    end
                end

                // Release wins over a threshold reached on the same edge.
                ST_PRESSED: begin
                    if (!button_level) begin
                        state         <= ST_IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                        click_pulse   <= 1'b1;
                        held          <= 1'b0;
                    end else if (long_hit_c) begin
                        state      <= ST_LONG;
                        count      <= CNT_ONE;
                        long_pulse <= 1'b1;
                    end else begin
                        count <= count_inc_c;
                    end
                end

                ST_LONG: begin
                    if (!button_level) begin
                        state         <= ST_IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (delay_hit_c) begin
                        state        <= ST_REPEAT;
                        count        <= CNT_ONE;
                        repeat_pulse <= 1'b1;
                    end else begin
                        count <= count_inc_c;
                    end
                end

                ST_REPEAT: begin
                    if (!button_level) begin
                        state         <= ST_IDLE;
                        count         <= '0;
                        release_pulse <= 1'b1;
                        held          <= 1'b0;
                    end else if (period_hit_c) begin
                        count        <= CNT_ONE;
                        repeat_pulse <= 1'b1;
                    end else begin
                        count <= count_inc_c;
                    end
                end

                default: begin
                    state <= ST_ARM;
                    count <= '0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder: a table of single-edge
// vectors for press/click/ARM behaviour, then hand-written multi-cycle
// sequences for long-press, repeat, disabled thresholds and async reset.
// Output vector order: {press, click, release, long, repeat, held}.
module tb_button_event_decoder;

    localparam int unsigned CNT_W = 24;

    logic             clock;
    logic             reset_n;
    logic             button_level;
    logic [CNT_W-1:0] long_periods;
    logic [CNT_W-1:0] repeat_delay;
    logic [CNT_W-1:0] repeat_period;
    logic             press_pulse;
    logic             click_pulse;
    logic             release_pulse;
    logic             long_pulse;
    logic             repeat_pulse;
    logic             held;

    int total;
    int bad;

    button_event_decoder #(.CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .button_level  (button_level),
        .long_periods  (long_periods),
        .repeat_delay  (repeat_delay),
        .repeat_period (repeat_period),
        .press_pulse   (press_pulse),
        .click_pulse   (click_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             level;
        logic [CNT_W-1:0] long_p;
        logic [CNT_W-1:0] delay;
        logic [CNT_W-1:0] period;
        logic [5:0]       exp;
    } vec_t;

    vec_t vecs[$];

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_PRESS = 6'b100001;
    localparam logic [5:0] O_HELD  = 6'b000001;
    localparam logic [5:0] O_CLICK = 6'b011000;

    function automatic logic [5:0] outs();
        return {press_pulse, click_pulse, release_pulse, long_pulse, repeat_pulse, held};
    endfunction

    function automatic void add(input logic lvl, input int unsigned lp, input int unsigned e);
        vec_t v;
        v.level  = lvl;
        v.long_p = CNT_W'(lp);
        v.delay  = CNT_W'(20);
        v.period = CNT_W'(4);
        v.exp    = 6'(e);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [5:0] exp);
        logic [5:0] act;
        act = outs();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Drive a level on the falling edge, sample just after the next rising edge.
    task automatic step(input logic lvl);
        @(negedge clock);
        button_level = lvl;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic [5:0] e;
        total         = 0;
        bad           = 0;
        reset_n       = 1'b1;
        button_level  = 1'b1;
        long_periods  = CNT_W'(10);
        repeat_delay  = CNT_W'(20);
        repeat_period = CNT_W'(4);
        #1 reset_n = 1'b0;
        #6;
        check("reset", 0, O_NONE);
        @(negedge clock);
        reset_n = 1'b1;

        // Level held through reset: no press until a 0 is seen.
        add(1, 10, O_NONE);
        add(1, 10, O_NONE);
        add(1, 10, O_NONE);
        add(0, 10, O_NONE);
        add(1, 10, O_PRESS);
        // Short press of 5 cycles -> click + release.
        for (int i = 0; i < 4; i++) add(1, 10, O_HELD);
        add(0, 10, O_CLICK);
        add(0, 10, O_NONE);
        // Release on the very edge where count reaches long_periods.
        add(1, 10, O_PRESS);
        for (int i = 0; i < 9; i++) add(1, 10, O_HELD);
        add(0, 10, O_CLICK);
        // Minimum press-to-press spacing of 2 cycles.
        add(1, 10, O_PRESS);
        add(0, 10, O_CLICK);
        add(1, 10, O_PRESS);
        add(0, 10, O_CLICK);
        add(0, 10, O_NONE);

        foreach (vecs[i]) begin
            long_periods  = vecs[i].long_p;
            repeat_delay  = vecs[i].delay;
            repeat_period = vecs[i].period;
            step(vecs[i].level);
            check("vec", i, vecs[i].exp);
        end

        // Long press then auto-repeat, release after 40 high cycles.
        long_periods  = CNT_W'(10);
        repeat_delay  = CNT_W'(20);
        repeat_period = CNT_W'(4);
        for (int i = 0; i <= 40; i++) begin
            step(i < 40);
            e = {i == 0, 1'b0, i == 40, i == 10, (i == 30 || i == 34 || i == 38), i < 40};
            check("long_repeat", i, e);
        end

        // Long disabled: 100-cycle hold still ends as a click.
        long_periods = '0;
        for (int i = 0; i <= 100; i++) begin
            step(i < 100);
            e = {i == 0, i == 100, i == 100, 1'b0, 1'b0, i < 100};
            check("long_off", i, e);
        end

        // period=0: exactly one repeat after the delay.
        long_periods  = CNT_W'(2);
        repeat_delay  = CNT_W'(2);
        repeat_period = '0;
        for (int i = 0; i <= 11; i++) begin
            step(i < 11);
            e = {i == 0, 1'b0, i == 11, i == 2, i == 4, i < 11};
            check("single_repeat", i, e);
        end

        // Threshold lowered mid-hold fires on the next edge; delay=0 blocks repeat.
        repeat_delay = '0;
        for (int i = 0; i <= 10; i++) begin
            long_periods = (i < 6) ? CNT_W'(1000) : CNT_W'(3);
            step(i < 10);
            e = {i == 0, 1'b0, i == 10, i == 6, 1'b0, i < 10};
            check("lowered", i, e);
        end

        // Async reset in REPEAT: outputs clear immediately, no release, back to ARM.
        long_periods  = CNT_W'(2);
        repeat_delay  = CNT_W'(2);
        repeat_period = CNT_W'(3);
        for (int i = 0; i < 6; i++) step(1'b1);
        check("pre_reset", 0, O_HELD);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", 0, O_NONE);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1);
        check("post_reset", 0, O_NONE);
        step(1'b1);
        check("post_reset", 1, O_NONE);
        step(1'b0);
        check("post_reset", 2, O_NONE);
        step(1'b1);
        check("post_reset", 3, O_PRESS);
        step(1'b0);
        check("post_reset", 4, O_CLICK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
